// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the single-bus T-state control unit: opcodes, bus source bits,
// ALU op codes, sequencer states and the strobe bundle produced by the step decoder.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Bus source bit positions; R0-R15 occupy bits 0..15.
  localparam logic [4:0] BUS_HI     = 5'd16;
  localparam logic [4:0] BUS_LO     = 5'd17;
  localparam logic [4:0] BUS_ZHI    = 5'd18;
  localparam logic [4:0] BUS_ZLO    = 5'd19;
  localparam logic [4:0] BUS_PC     = 5'd20;
  localparam logic [4:0] BUS_MDR    = 5'd21;
  localparam logic [4:0] BUS_INPORT = 5'd22;
  localparam logic [4:0] BUS_C      = 5'd23;

  localparam logic [4:0] ALU_NONE = 5'd0;
  localparam logic [4:0] ALU_ADD  = OP_ADD;

  typedef enum logic [3:0] {
    StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StHalted, StFault
  } state_e;

  typedef enum logic [2:0] {
    ClsRegReg, ClsAddi, ClsMulDiv, ClsNop, ClsHalt, ClsIllegal
  } op_class_e;

  typedef struct packed {
    logic [31:0] bus_sel;
    logic [15:0] reg_in;
    logic        pc_in;
    logic        ir_in;
    logic        y_in;
    logic        z_in;
    logic        mar_in;
    logic        mdr_in;
    logic        hi_in;
    logic        lo_in;
    logic        inc_pc;
    logic        mem_read;
    logic [4:0]  alu_op;
    logic        running;
    logic        halted;
    logic        fault;
    logic        illegal_op;
  } strobes_t;

  function automatic op_class_e op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: op_class = ClsRegReg;
      OP_ADDI:                       op_class = ClsAddi;
      OP_MUL, OP_DIV:                op_class = ClsMulDiv;
      OP_NOP:                        op_class = ClsNop;
      OP_HALT:                       op_class = ClsHalt;
      default:                       op_class = ClsIllegal;
    endcase
  endfunction

  function automatic logic [31:0] bus_src(input logic [4:0] idx);
    bus_src = 32'd1 << idx;
  endfunction

endpackage

// File: rtl/ctrl_step_decode.sv
// Combinational Moore decode of sequencer state plus IR fields into every datapath strobe.
module ctrl_step_decode
  import cpu_ctrl_pkg::*;
(
  input  state_e      state,
  input  logic        first_t1,
  input  logic [4:0]  op,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic [3:0]  rc,
  output strobes_t    strb
);

  op_class_e cls;
  assign cls = op_class(op);

  always_comb begin
    strb = '0;
    unique case (state)
      StT0: begin
        strb.bus_sel = bus_src(BUS_PC);
        strb.mar_in  = 1'b1;
        strb.inc_pc  = 1'b1;
        strb.z_in    = 1'b1;
        strb.alu_op  = ALU_ADD;
        strb.running = 1'b1;
      end
      StT1: begin
        strb.bus_sel  = bus_src(BUS_ZLO);
        strb.pc_in    = first_t1;
        strb.mem_read = 1'b1;
        strb.mdr_in   = 1'b1;
        strb.running  = 1'b1;
      end
      StT2: begin
        strb.bus_sel = bus_src(BUS_MDR);
        strb.ir_in   = 1'b1;
        strb.running = 1'b1;
      end
      StT3: begin
        strb.running = 1'b1;
        case (cls)
          ClsRegReg, ClsAddi: begin
            strb.bus_sel = bus_src({1'b0, rb});
            strb.y_in    = 1'b1;
          end
          ClsMulDiv: begin
            strb.bus_sel = bus_src({1'b0, ra});
            strb.y_in    = 1'b1;
          end
          ClsIllegal: strb.illegal_op = 1'b1;
          default: ;
        endcase
      end
      StT4: begin
        strb.running = 1'b1;
        case (cls)
          ClsRegReg: begin
            strb.bus_sel = bus_src({1'b0, rc});
            strb.z_in    = 1'b1;
            strb.alu_op  = op;
          end
          ClsAddi: begin
            strb.bus_sel = bus_src(BUS_C);
            strb.z_in    = 1'b1;
            strb.alu_op  = ALU_ADD;
          end
          ClsMulDiv: begin
            strb.bus_sel = bus_src({1'b0, rb});
            strb.z_in    = 1'b1;
            strb.alu_op  = op;
          end
          default: ;
        endcase
      end
      StT5: begin
        strb.running = 1'b1;
        strb.bus_sel = bus_src(BUS_ZLO);
        if (cls == ClsMulDiv) strb.lo_in = 1'b1;
        else                  strb.reg_in = 16'd1 << ra;
      end
      StT6: begin
        strb.running = 1'b1;
        strb.bus_sel = bus_src(BUS_ZHI);
        strb.hi_in   = 1'b1;
      end
      StHalted: strb.halted = 1'b1;
      StFault:  strb.fault  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_control_sequencer.sv
// T-state control unit: state register, T1 memory wait counter and next-state logic;
// all strobes come from ctrl_step_decode.
module bus_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [31:0] bus_sel,
  output logic [15:0] reg_in,
  output logic        pc_in,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        inc_pc,
  output logic        mem_read,
  output logic [4:0]  alu_op,
  output logic        running,
  output logic        halted,
  output logic        fault,
  output logic        illegal_op
);

  localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] cnt_inc;
  op_class_e  cls;
  strobes_t   strb;
  logic       unused_ir;

  assign cls       = op_class(ir[31:27]);
  assign cnt_inc   = wait_cnt_q + 8'd1;
  assign unused_ir = ^ir[14:0];

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    unique case (state_q)
      StIdle, StHalted: if (start) state_d = StT0;
      StT0: state_d = StT1;
      StT1: begin
        wait_cnt_d = cnt_inc;
        if (mem_ready) begin
          state_d    = StT2;
          wait_cnt_d = '0;
        end else if (cnt_inc >= TimeoutCnt) begin
          state_d    = StFault;
          wait_cnt_d = '0;
        end
      end
      StT2: state_d = StT3;
      StT3: begin
        case (cls)
          ClsNop, ClsIllegal: state_d = StT0;
          ClsHalt:            state_d = StHalted;
          default:            state_d = StT4;
        endcase
      end
      StT4: state_d = StT5;
      StT5: state_d = (cls == ClsMulDiv) ? StT6 : StT0;
      StT6: state_d = StT0;
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  ctrl_step_decode u_decode (
    .state    (state_q),
    .first_t1 (wait_cnt_q == 8'd0),
    .op       (ir[31:27]),
    .ra       (ir[26:23]),
    .rb       (ir[22:19]),
    .rc       (ir[18:15]),
    .strb     (strb)
  );

  assign bus_sel    = strb.bus_sel;
  assign reg_in     = strb.reg_in;
  assign pc_in      = strb.pc_in;
  assign ir_in      = strb.ir_in;
  assign y_in       = strb.y_in;
  assign z_in       = strb.z_in;
  assign mar_in     = strb.mar_in;
  assign mdr_in     = strb.mdr_in;
  assign hi_in      = strb.hi_in;
  assign lo_in      = strb.lo_in;
  assign inc_pc     = strb.inc_pc;
  assign mem_read   = strb.mem_read;
  assign alu_op     = strb.alu_op;
  assign running    = strb.running;
  assign halted     = strb.halted;
  assign fault      = strb.fault;
  assign illegal_op = strb.illegal_op;

endmodule

// File: tb/tb_bus_control_sequencer.sv
// Self-checking bench for bus_control_sequencer: directed cases plus random instruction mix
// compared cycle by cycle against an instruction-level model of the expected strobes.
module tb_bus_control_sequencer;

  logic        clk, clr, start, mem_ready;
  logic [31:0] ir;
  logic [31:0] bus_sel;
  logic [15:0] reg_in;
  logic        pc_in, ir_in, y_in, z_in, mar_in, mdr_in, hi_in, lo_in;
  logic        inc_pc, mem_read, running, halted, fault, illegal_op;
  logic [4:0]  alu_op;
  logic [13:0] flags;

  int checks = 0;
  int errors = 0;

  localparam logic [13:0] M_PC  = 14'h2000, M_IR  = 14'h1000, M_Y   = 14'h0800;
  localparam logic [13:0] M_Z   = 14'h0400, M_MAR = 14'h0200, M_MDR = 14'h0100;
  localparam logic [13:0] M_HI  = 14'h0080, M_LO  = 14'h0040, M_INC = 14'h0020;
  localparam logic [13:0] M_MRD = 14'h0010, M_RUN = 14'h0008, M_HLT = 14'h0004;
  localparam logic [13:0] M_FLT = 14'h0002, M_ILL = 14'h0001, M_NONE = 14'h0000;
  localparam int unsigned TIMEOUT = 15;

  bus_control_sequencer #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .ir         (ir),
    .mem_ready  (mem_ready),
    .bus_sel    (bus_sel),
    .reg_in     (reg_in),
    .pc_in      (pc_in),
    .ir_in      (ir_in),
    .y_in       (y_in),
    .z_in       (z_in),
    .mar_in     (mar_in),
    .mdr_in     (mdr_in),
    .hi_in      (hi_in),
    .lo_in      (lo_in),
    .inc_pc     (inc_pc),
    .mem_read   (mem_read),
    .alu_op     (alu_op),
    .running    (running),
    .halted     (halted),
    .fault      (fault),
    .illegal_op (illegal_op)
  );

  assign flags = {pc_in, ir_in, y_in, z_in, mar_in, mdr_in, hi_in, lo_in,
                  inc_pc, mem_read, running, halted, fault, illegal_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Check the current cycle's outputs, then advance to 1ns after the next rising edge.
  task automatic cyc(input string tag, input logic [31:0] eb, input logic [15:0] er,
                     input logic [13:0] ef, input logic [4:0] ea);
    #1;
    checks++;
    assert ({bus_sel, reg_in, flags, alu_op} === {eb, er, ef, ea}) else begin
      errors++;
      $error("FAIL %s got bus=%h reg=%h flg=%h alu=%h want bus=%h reg=%h flg=%h alu=%h",
             tag, bus_sel, reg_in, flags, alu_op, eb, er, ef, ea);
    end
    checks++;
    assert ($countones(bus_sel) <= 1) else begin
      errors++;
      $error("FAIL %s_onehot got bus=%h want popcount<=1", tag, bus_sel);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic kick();
    start = 1'b1;
    cyc("idle_start", 32'h0, 16'h0, M_NONE, 5'd0);
    start = 1'b0;
  endtask

  task automatic fetch(input int w);
    start = 1'($urandom);
    cyc("t0", 32'h1 << 20, 16'h0, M_MAR | M_Z | M_INC | M_RUN, 5'd3);
    for (int k = 0; k <= w; k++) begin
      mem_ready = (k == w);
      start     = 1'($urandom);
      cyc("t1", 32'h1 << 19, 16'h0, (k == 0 ? M_PC : M_NONE) | M_MDR | M_MRD | M_RUN, 5'd0);
    end
    mem_ready = 1'($urandom);
    cyc("t2", 32'h1 << 21, 16'h0, M_IR | M_RUN, 5'd0);
  endtask

  // Execute-phase expectations derived from the instruction's meaning.
  task automatic exec(input logic [31:0] instr);
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    op = instr[31:27]; ra = instr[26:23]; rb = instr[22:19]; rc = instr[18:15];
    mem_ready = 1'($urandom);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        cyc("rr_t3", 32'h1 << rb, 16'h0, M_Y | M_RUN, 5'd0);
        cyc("rr_t4", 32'h1 << rc, 16'h0, M_Z | M_RUN, op);
        cyc("rr_t5", 32'h1 << 19, 16'h1 << ra, M_RUN, 5'd0);
      end
      5'b01100: begin
        cyc("addi_t3", 32'h1 << rb, 16'h0, M_Y | M_RUN, 5'd0);
        cyc("addi_t4", 32'h1 << 23, 16'h0, M_Z | M_RUN, 5'd3);
        cyc("addi_t5", 32'h1 << 19, 16'h1 << ra, M_RUN, 5'd0);
      end
      5'b01111, 5'b10000: begin
        cyc("md_t3", 32'h1 << ra, 16'h0, M_Y | M_RUN, 5'd0);
        cyc("md_t4", 32'h1 << rb, 16'h0, M_Z | M_RUN, op);
        cyc("md_t5", 32'h1 << 19, 16'h0, M_LO | M_RUN, 5'd0);
        cyc("md_t6", 32'h1 << 18, 16'h0, M_HI | M_RUN, 5'd0);
      end
      5'b11010: cyc("nop_t3", 32'h0, 16'h0, M_RUN, 5'd0);
      5'b11011: begin
        start = 1'b0;
        cyc("halt_t3", 32'h0, 16'h0, M_RUN, 5'd0);
        cyc("halted", 32'h0, 16'h0, M_HLT, 5'd0);
      end
      default: cyc("ill_t3", 32'h0, 16'h0, M_RUN | M_ILL, 5'd0);
    endcase
  endtask

  task automatic run(input logic [31:0] instr, input int w);
    ir = instr;
    fetch(w);
    exec(instr);
    if (instr[31:27] == 5'b11011) begin
      start = 1'b1;
      cyc("halted_start", 32'h0, 16'h0, M_HLT, 5'd0);
      start = 1'b0;
    end
  endtask

  logic [4:0] legal_ops [9] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01100,
                                 5'b01111, 5'b10000, 5'b11010, 5'b11011};

  initial begin
    clr = 1'b1; start = 1'b0; mem_ready = 1'b0; ir = 32'h0;
    #2;
    cyc("reset", 32'h0, 16'h0, M_NONE, 5'd0);
    clr = 1'b0;
    cyc("idle_hold", 32'h0, 16'h0, M_NONE, 5'd0);
    kick();

    run(32'h1891_8000, 0);                                   // ADD R1,R2,R3
    run({5'b01111, 4'd4, 4'd5, 4'd0, 15'd0}, 0);             // MUL R4,R5
    run({5'b00100, 4'd7, 4'd7, 4'd7, 15'h1234}, 2);          // SUB, ready on 3rd T1
    run({5'b11111, 4'd1, 4'd2, 4'd3, 15'd0}, 0);             // undefined opcode
    run({5'b01100, 4'd15, 4'd0, 4'd9, 15'h7fff}, TIMEOUT - 1); // ADDI, longest legal wait
    run({5'b10000, 4'd0, 4'd15, 4'd1, 15'd0}, 1);            // DIV
    run({5'b11011, 27'd0}, 0);                               // HALT then restart

    // clr asserted mid-T4 of an ADD
    ir = 32'h1891_8000;
    fetch(0);
    cyc("clr_t3", 32'h1 << 2, 16'h0, M_Y | M_RUN, 5'd0);
    clr = 1'b1;
    cyc("clr_t4", 32'h0, 16'h0, M_NONE, 5'd0);
    clr = 1'b0;
    cyc("after_clr", 32'h0, 16'h0, M_NONE, 5'd0);
    kick();

    for (int n = 0; n < 40; n++) begin
      logic [31:0] instr;
      instr = $urandom;
      if ($urandom_range(0, 7) != 0) instr[31:27] = legal_ops[$urandom_range(0, 8)];
      run(instr, int'($urandom_range(0, 5)));
    end

    // memory never answers: fault after TIMEOUT cycles in T1, start ignored
    ir = $urandom;
    cyc("to_t0", 32'h1 << 20, 16'h0, M_MAR | M_Z | M_INC | M_RUN, 5'd3);
    mem_ready = 1'b0;
    for (int k = 0; k < int'(TIMEOUT); k++) begin
      start = 1'($urandom);
      cyc("to_t1", 32'h1 << 19, 16'h0, (k == 0 ? M_PC : M_NONE) | M_MDR | M_MRD | M_RUN, 5'd0);
    end
    start = 1'b1;
    for (int k = 0; k < 3; k++) cyc("fault", 32'h0, 16'h0, M_FLT, 5'd0);
    start = 1'b0;
    clr = 1'b1;
    cyc("fault_clr", 32'h0, 16'h0, M_NONE, 5'd0);
    clr = 1'b0;
    cyc("fault_idle", 32'h0, 16'h0, M_NONE, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
